univ_shift_reg: RTL and testbench

Parametrised N-bit universal shift register with synchronous clear, parallel load, logical and arithmetic shifts, rotates, and a counted burst mode driven by a small FSM. A single `en` cycle performs one operation. A `start` pulse runs a programmed number of consecutive shift or rotate operations, reported with `busy` and `done`. It is the next generation of the team's bidirectional shift register and serves as a serializer, deserializer or barrel-style shifter inside datapath blocks.

---
 rtl/univ_shift_reg.sv | 153 +++++++++++++++
 tb/tb_univ_shift_reg.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//
// N-bit universal shift register. A single `en` cycle performs one operation
// selected by `mode` (hold, shifts, rotates, arithmetic shift right, parallel
// load, zero). A `start` pulse with a shift/rotate mode runs `count`
// consecutive operations under a small IDLE/RUN/DONE controller.
//
// Ports
//   clk     : clock, all state updates on the rising edge
//   clr     : synchronous active-high clear (aborts a burst, no `done`)
//   en      : perform one `mode` operation this cycle (idle only)
//   mode    : 0 HOLD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 ASR, 6 LOAD, 7 ZERO
//   Din_L   : serial input entering at the MSB end (SHR)
//   Din_R   : serial input entering at the LSB end (SHL)
//   par_in  : parallel load data
//   start   : begin a burst of `mode` operations, `count` long
//   count   : burst length (0 gives an immediate `done`)
//   q       : register contents
//   Dout_L  : q[N-1]
//   Dout_R  : q[0]
//   busy    : burst in progress
//   done    : one-cycle pulse after a burst completes
// -----------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             Din_L,
    input  logic             Din_R,
    input  logic [N-1:0]     par_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [N-1:0]     q,
    output logic             Dout_L,
    output logic             Dout_R,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_SHL  = 3'd1,
        OP_SHR  = 3'd2,
        OP_ROL  = 3'd3,
        OP_ROR  = 3'd4,
        OP_ASR  = 3'd5,
        OP_LOAD = 3'd6,
        OP_ZERO = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     q_q, q_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    op_e              op_q, op_d;

    logic             mode_is_shift;

    // One operation applied to the current contents.
    function automatic logic [N-1:0] apply_op(
        input op_e          o,
        input logic [N-1:0] cur,
        input logic         dl,
        input logic         dr,
        input logic [N-1:0] pin
    );
        logic [N-1:0] r;
        case (o)
            OP_SHL:  r = {cur[N-2:0], dr};
            OP_SHR:  r = {dl, cur[N-1:1]};
            OP_ROL:  r = {cur[N-2:0], cur[N-1]};
            OP_ROR:  r = {cur[0], cur[N-1:1]};
            OP_ASR:  r = {cur[N-1], cur[N-1:1]};
            OP_LOAD: r = pin;
            OP_ZERO: r = '0;
            default: r = cur;
        endcase
        return r;
    endfunction

    // Only the shift/rotate modes can be burst; other modes ignore `start`.
    assign mode_is_shift = (mode >= 3'd1) && (mode <= 3'd5);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        op_d    = op_q;

        case (state_q)
            S_RUN: begin
                // Burst inputs are frozen in op_q; serial inputs stream live.
                q_d   = apply_op(op_q, q_q, Din_L, Din_R, par_in);
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end

            default: begin  // S_IDLE and S_DONE behave identically
                if (start && mode_is_shift) begin
                    if (count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        op_d    = op_e'(mode);
                        rem_d   = count;
                        state_d = S_RUN;
                    end
                end else begin
                    if (en) begin
                        q_d = apply_op(op_e'(mode), q_q, Din_L, Din_R, par_in);
                    end
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (clr) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            op_q    <= OP_HOLD;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    assign q      = q_q;
    assign Dout_L = q_q[N-1];
    assign Dout_R = q_q[0];
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
//
// Self-checking bench for univ_shift_reg (N=8, CNT_W=4). Inputs are driven
// after the falling edge, the reference model advances on each rising edge,
// and DUT outputs are compared on the following falling edge. The reference
// model works on integers with plain arithmetic and tracks a burst only as a
// count of operations still to perform.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int N     = 8;
    localparam int CNT_W = 4;
    localparam int M     = 1 << N;

    logic             clk = 1'b0;
    logic             clr;
    logic             en;
    logic [2:0]       mode;
    logic             Din_L;
    logic             Din_R;
    logic [N-1:0]     par_in;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [N-1:0]     q;
    logic             Dout_L;
    logic             Dout_R;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_q    = 0;  // register value as an integer 0..M-1
    int m_left = 0;  // burst operations still to perform
    int m_op   = 0;  // burst operation
    bit m_done = 1'b0;

    univ_shift_reg #(.N(N), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .clr    (clr),
        .en     (en),
        .mode   (mode),
        .Din_L  (Din_L),
        .Din_R  (Din_R),
        .par_in (par_in),
        .start  (start),
        .count  (count),
        .q      (q),
        .Dout_L (Dout_L),
        .Dout_R (Dout_R),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Operation semantics expressed as integer arithmetic.
    function automatic int model_op(int o, int v, int dl, int dr, int pin);
        case (o)
            1: return (v * 2 + dr) % M;                          // SHL
            2: return v / 2 + dl * (M / 2);                      // SHR
            3: return (v * 2) % M + v / (M / 2);                 // ROL
            4: return v / 2 + (v % 2) * (M / 2);                 // ROR
            5: return v / 2 + ((v >= M / 2) ? M / 2 : 0);        // ASR
            6: return pin;                                       // LOAD
            7: return 0;                                         // ZERO
            default: return v;                                   // HOLD
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".q"},      int'(q),      m_q);
        check({tag, ".busy"},   int'(busy),   int'(m_left > 0));
        check({tag, ".done"},   int'(done),   int'(m_done));
        check({tag, ".Dout_L"}, int'(Dout_L), m_q / (M / 2));
        check({tag, ".Dout_R"}, int'(Dout_R), m_q % 2);
    endtask

    // One clock: model advances at the rising edge, compare at the falling.
    task automatic tick(input string tag);
        @(posedge clk);
        if (clr) begin
            m_q    = 0;
            m_left = 0;
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_q    = model_op(m_op, m_q, int'(Din_L), int'(Din_R), int'(par_in));
            m_left = m_left - 1;
            m_done = (m_left == 0);
        end else if (start && mode >= 3'd1 && mode <= 3'd5) begin
            m_left = int'(count);
            m_op   = int'(mode);
            m_done = (count == '0);
        end else begin
            if (en) m_q = model_op(int'(mode), m_q, int'(Din_L), int'(Din_R), int'(par_in));
            m_done = 1'b0;
        end
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic idle_inputs();
        clr = 1'b0; en = 1'b0; mode = 3'd0; start = 1'b0; count = '0;
        Din_L = 1'b0; Din_R = 1'b0; par_in = '0;
    endtask

    task automatic single(input logic [2:0] md, input logic [N-1:0] pin,
                          input logic dl, input logic dr, input string tag);
        idle_inputs();
        en = 1'b1; mode = md; par_in = pin; Din_L = dl; Din_R = dr;
        tick(tag);
        idle_inputs();
    endtask

    int ser_seq[8] = '{0, 1, 0, 1, 1, 0, 1, 0};

    initial begin
        idle_inputs();
        @(negedge clk);

        // Reset
        clr = 1'b1;
        tick("reset");
        check("reset.q_const", int'(q), 0);
        single(3'd6, 8'hA5, 1'b0, 1'b0, "load_a5");
        clr = 1'b1;
        tick("clr_after_load");
        check("clr.q_const", int'(q), 0);
        clr = 1'b1; en = 1'b1; mode = 3'd6; par_in = 8'hFF; start = 1'b1; count = 4'd3;
        tick("clr_with_en_start");
        check("clr_hold.q_const", int'(q), 0);
        idle_inputs();

        // Single operations
        single(3'd6, 8'hA5, 1'b0, 1'b0, "load_a5b");
        single(3'd1, 8'h00, 1'b0, 1'b1, "shl");
        check("shl.q_const", int'(q), 8'h4B);
        single(3'd2, 8'h00, 1'b0, 1'b0, "shr");
        check("shr.q_const", int'(q), 8'h25);
        single(3'd6, 8'h80, 1'b0, 1'b0, "load_80");
        single(3'd5, 8'h00, 1'b0, 1'b0, "asr");
        check("asr.q_const", int'(q), 8'hC0);
        single(3'd4, 8'h00, 1'b0, 1'b0, "ror");
        check("ror.q_const", int'(q), 8'h60);
        single(3'd7, 8'h00, 1'b0, 1'b0, "zero");
        check("zero.q_const", int'(q), 8'h00);
        single(3'd6, 8'h3C, 1'b0, 1'b0, "load_3c");
        single(3'd0, 8'hFF, 1'b1, 1'b1, "hold");
        check("hold.q_const", int'(q), 8'h3C);

        // ROL burst with en toggling underneath
        single(3'd6, 8'h81, 1'b0, 1'b0, "load_81");
        start = 1'b1; mode = 3'd3; count = 4'd3;
        tick("rol_t0");
        check("rol_t0.busy_const", int'(busy), 1);
        idle_inputs();
        en = 1'b1; mode = 3'd6; par_in = 8'hFF;
        tick("rol_t1");
        check("rol_t1.q_const", int'(q), 8'h03);
        en = 1'b0;
        tick("rol_t2");
        check("rol_t2.q_const", int'(q), 8'h06);
        en = 1'b1;
        tick("rol_t3");
        check("rol_t3.q_const", int'(q), 8'h0C);
        check("rol_done_const", int'(done), 1);
        idle_inputs();
        tick("rol_after");
        check("rol_after.done_const", int'(done), 0);

        // Zero-length burst
        start = 1'b1; mode = 3'd1; count = 4'd0; Din_R = 1'b1;
        tick("cnt0");
        check("cnt0.done_const", int'(done), 1);
        check("cnt0.busy_const", int'(busy), 0);
        check("cnt0.q_const", int'(q), 8'h0C);
        idle_inputs();
        tick("cnt0_after");

        // start with LOAD behaves as a plain en cycle
        start = 1'b1; en = 1'b1; mode = 3'd6; par_in = 8'h77; count = 4'd4;
        tick("start_load");
        check("start_load.q_const", int'(q), 8'h77);
        idle_inputs();

        // Abort a running burst
        single(3'd6, 8'hF0, 1'b0, 1'b0, "load_f0");
        start = 1'b1; mode = 3'd4; count = 4'd5;
        tick("abort_t0");
        idle_inputs();
        tick("abort_t1");
        clr = 1'b1;
        tick("abort_clr");
        check("abort.q_const", int'(q), 0);
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick("abort_quiet");
            check("abort_quiet.done_const", int'(done), 0);
        end

        // Serializer
        single(3'd6, 8'h5A, 1'b0, 1'b0, "load_5a");
        start = 1'b1; mode = 3'd2; count = 4'd8; Din_L = 1'b1;
        tick("ser_t0");
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("ser.Dout_R_seq", int'(Dout_R), ser_seq[i]);
            tick("ser_run");
        end
        check("ser.final_q_const", int'(q), 8'hFF);
        check("ser.done_const", int'(done), 1);
        start = 1'b1; mode = 3'd3; count = 4'd2;
        tick("b2b_start");
        check("b2b.busy_const", int'(busy), 1);
        check("b2b.done_const", int'(done), 0);
        idle_inputs();
        for (int i = 0; i < 3; i++) tick("b2b_run");

        // Randomised stimulus against the model
        for (int i = 0; i < 400; i++) begin
            clr    = ($urandom_range(0, 39) == 0);
            en     = $urandom_range(0, 1);
            mode   = 3'($urandom_range(0, 7));
            start  = ($urandom_range(0, 5) == 0);
            count  = CNT_W'($urandom_range(0, 6));
            Din_L  = $urandom_range(0, 1);
            Din_R  = $urandom_range(0, 1);
            par_in = N'($urandom);
            tick("rand");
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) tick("drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
